axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the handshake and AXI address ports.
REQ-002 Parameter DATA_W, default 32, data width (allowed 32 or 64); arsize_o/awsize_o = log2(DATA_W/8).
REQ-003 Parameter LEN_W, default 4, burst-length field width; a burst carries 1..2^LEN_W beats.
REQ-004 Ports, in order: clk_i in 1, the single clock; rst_i in 1, reset, asynchronous and active-high.
REQ-005 hs_read_i in 1 read request; hs_write_i in 1 write request; hs_addr_i in ADDR_W start address; hs_len_i in LEN_W beats-1.
REQ-006 hs_ready_o out 1 idle/accepting; hs_done_o out 1 one-cycle completion pulse; hs_err_o out 1 error flag, valid with hs_done_o.
REQ-007 hs_wdata_i in DATA_W write beat; hs_wvalid_i in 1; hs_wready_o out 1.
REQ-008 hs_rdata_o out DATA_W read beat; hs_rvalid_o out 1; hs_rready_i in 1.
REQ-009 AR channel: arvalid_o out 1; arready_i in 1; araddr_o out ADDR_W; arlen_o out 8; arsize_o out 3; arburst_o out 2.
REQ-010 R channel: rvalid_i in 1; rready_o out 1; rdata_i in DATA_W; rresp_i in 2; rlast_i in 1.
REQ-011 AW channel: awvalid_o, awready_i, awaddr_o, awlen_o, awsize_o, awburst_o, with AR widths.
REQ-012 W channel: wvalid_o out 1; wready_i in 1; wdata_o out DATA_W; wlast_o out 1.
REQ-013 B channel: bvalid_i in 1; bready_o out 1; bresp_i in 2.

Function
REQ-014 FSM states: IDLE, AR, R, WR, B; hs_ready_o = 1 only in IDLE.
REQ-015 In IDLE, a request is accepted on a clock edge where hs_read_i or hs_write_i = 1 (level-sensitive); if both are 1, the read wins and the write stays pending.
REQ-016 On acceptance, register hs_addr_i and hs_len_i; AXI address and length outputs come from these registers, never directly from hs_* inputs.
REQ-017 arlen_o/awlen_o = zero-extended registered length; arburst_o/awburst_o = 2'b01 (INCR); outputs other than these constants are 0 outside their active states.
REQ-018 AR: arvalid_o = 1 until the arready_i handshake, then go to R; arvalid_o is never dropped before the handshake.
REQ-019 R: rready_o = hs_rready_i; hs_rvalid_o = rvalid_i; hs_rdata_o = rdata_i (combinational pass-through); a beat transfers when rvalid_i && rready_o.
REQ-020 R: a beat counter counts transferred beats; on the final beat (count == len), go to IDLE.
REQ-021 R: an error is recorded if rlast_i on a transferred beat differs from (count == len).
REQ-022 WR: awvalid_o and wvalid_o are driven concurrently.
REQ-023 WR: awvalid_o drops after its handshake; an aw_done flag is set by the handshake.
REQ-024 WR: wvalid_o = hs_wvalid_i; hs_wready_o = wready_i; wdata_o = hs_wdata_i; wlast_o = (count == len).
REQ-025 WR: leave for B only when aw_done (or an AW handshake in this cycle) and the last W beat has transferred, in any order, including the same cycle.
REQ-026 B: bready_o = 1 until bvalid_i, then go to IDLE.
REQ-027 Any rresp_i or bresp_i value other than 2'b00 on a transferred beat or response records an error.
REQ-028 Error is sticky per transaction and cleared on acceptance; hs_err_o = the recorded error, held until the next acceptance.
REQ-029 hs_done_o pulses for exactly one cycle, in the cycle after the final R beat or the B handshake.
REQ-030 The beat counter is LEN_W bits and resets to 0 on acceptance; no wrap occurs, because the transfer ends at count == len.
REQ-031 Handshake inputs are ignored outside IDLE.

Reset
REQ-032 While rst_i = 1, asynchronously: state = IDLE, counters/flags/registers = 0, all valid/ready/last/done/err outputs = 0, hs_ready_o = 1 after release.
REQ-033 Reset asserted mid-burst aborts the transaction immediately; no completion pulse is generated.

Verification
REQ-034 Read, len = 3, addr = 0x100, arready_i delayed 2 cycles -> arlen_o = 3 and araddr_o = 0x100 are held stable; 4 beats are passed through; rlast_i on beat 4; hs_done_o pulses once; hs_err_o = 0.
REQ-035 Write, len = 0, awready_i 3 cycles after wready_i -> wlast_o = 1 on the single beat; B is entered only after AW completes; bresp_i = 2'b00 -> hs_done_o = 1 with hs_err_o = 0.
REQ-036 Write, len = 7, hs_wvalid_i gapped, AW and last W handshake in the same cycle -> 8 beats; wlast_o only on beat 8; bresp_i = 2'b10 -> hs_err_o = 1.
REQ-037 Read, len = 2, with rlast_i asserted early on beat 2 and hs_rready_i stalling -> rready_o follows the stalls; 3 beats complete; hs_err_o = 1.
REQ-038 hs_read_i and hs_write_i both 1 in IDLE -> the read executes first, then the write is accepted in IDLE.
REQ-039 rst_i asserted mid-write -> all outputs are 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master: runs each accepted read or write request as one AXI4 INCR burst.
// Data beats pass combinationally between the handshake side and the R/W channels.
module axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hs_read_i,
    input  logic              hs_write_i,
    input  logic [ADDR_W-1:0] hs_addr_i,
    input  logic [LEN_W-1:0]  hs_len_i,
    output logic              hs_ready_o,
    output logic              hs_done_o,
    output logic              hs_err_o,
    input  logic [DATA_W-1:0] hs_wdata_i,
    input  logic              hs_wvalid_i,
    output logic              hs_wready_o,
    output logic [DATA_W-1:0] hs_rdata_o,
    output logic              hs_rvalid_o,
    input  logic              hs_rready_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wlast_o,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i
);
    localparam logic [2:0] SIZE = 3'($clog2(DATA_W / 8));
    typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic              arvalid_q, awvalid_q, bready_q, done_q, err_q, aw_done_q, w_done_q;
    logic              in_ar, in_r, in_wr, w_open, last, r_hs, aw_hs, w_hs;
    assign in_ar  = state_q == AR;
    assign in_r   = state_q == R;
    assign in_wr  = state_q == WR;
    // once the last W beat is taken, W is closed while AW may still be pending
    assign w_open = in_wr && !w_done_q;
    assign last   = cnt_q == len_q;
    assign r_hs   = in_r && rvalid_i && hs_rready_i;
    assign aw_hs  = awvalid_q && awready_i;
    assign w_hs   = w_open && hs_wvalid_i && wready_i;
    assign hs_ready_o  = state_q == IDLE && !rst_i;
    assign hs_done_o   = done_q;
    assign hs_err_o    = err_q;
    assign arvalid_o   = arvalid_q;
    assign araddr_o    = in_ar ? addr_q : '0;
    assign arlen_o     = in_ar ? 8'(len_q) : '0;
    assign arsize_o    = SIZE;
    assign arburst_o   = 2'b01;
    assign rready_o    = in_r && hs_rready_i;
    assign hs_rvalid_o = in_r && rvalid_i;
    assign hs_rdata_o  = in_r ? rdata_i : '0;
    assign awvalid_o   = awvalid_q;
    assign awaddr_o    = in_wr ? addr_q : '0;
    assign awlen_o     = in_wr ? 8'(len_q) : '0;
    assign awsize_o    = SIZE;
    assign awburst_o   = 2'b01;
    assign wvalid_o    = w_open && hs_wvalid_i;
    assign hs_wready_o = w_open && wready_i;
    assign wdata_o     = in_wr ? hs_wdata_i : '0;
    assign wlast_o     = w_open && last;
    assign bready_o    = bready_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (hs_read_i || hs_write_i) begin
                    state_q   <= hs_read_i ? AR : WR;
                    arvalid_q <= hs_read_i;
                    awvalid_q <= !hs_read_i;
                    addr_q    <= hs_addr_i;
                    len_q     <= hs_len_i;
                    cnt_q     <= '0;
                    err_q     <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
                AR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    state_q   <= R;
                end
                R: if (r_hs) begin
                    cnt_q   <= last ? cnt_q : cnt_q + LEN_W'(1);
                    err_q   <= err_q || rresp_i != 2'b00 || rlast_i != last;
                    state_q <= last ? IDLE : R;
                    done_q  <= last;
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        cnt_q    <= last ? cnt_q : cnt_q + LEN_W'(1);
                        w_done_q <= last;
                    end
                    // AW and the last W beat may complete in either order or together
                    if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && last))) begin
                        state_q  <= B;
                        bready_q <= 1'b1;
                    end
                end
                B: if (bvalid_i) begin
                    bready_q <= 1'b0;
                    err_q    <= err_q || bresp_i != 2'b00;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed read/write bursts with hand-computed expectations.
module tb_axi_burst_master;
    logic        clk_i = 1'b0, rst_i;
    logic        hs_read_i, hs_write_i, hs_ready_o, hs_done_o, hs_err_o;
    logic [31:0] hs_addr_i, hs_wdata_i, hs_rdata_o, araddr_o, awaddr_o, rdata_i, wdata_o;
    logic [3:0]  hs_len_i;
    logic        hs_wvalid_i, hs_wready_o, hs_rvalid_o, hs_rready_i;
    logic        arvalid_o, arready_i, rvalid_i, rready_o, rlast_i;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, wlast_o, bvalid_i, bready_o;
    logic [7:0]  arlen_o, awlen_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o, rresp_i, bresp_i;
    int vectors = 0, miscompares = 0;

    axi_burst_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .hs_read_i(hs_read_i), .hs_write_i(hs_write_i), .hs_addr_i(hs_addr_i), .hs_len_i(hs_len_i),
        .hs_ready_o(hs_ready_o), .hs_done_o(hs_done_o), .hs_err_o(hs_err_o),
        .hs_wdata_i(hs_wdata_i), .hs_wvalid_i(hs_wvalid_i), .hs_wready_o(hs_wready_o),
        .hs_rdata_o(hs_rdata_o), .hs_rvalid_o(hs_rvalid_o), .hs_rready_i(hs_rready_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1; hs_read_i = 0; hs_write_i = 0; hs_addr_i = 0; hs_len_i = 0;
        hs_wdata_i = 0; hs_wvalid_i = 0; hs_rready_i = 0; arready_i = 0; rvalid_i = 0;
        rdata_i = 0; rresp_i = 0; rlast_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        #2;
        chk("rst_ready", hs_ready_o, 0);
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_done", hs_done_o, 0);
        chk("rst_bready", bready_o, 0);
        @(negedge clk_i); rst_i = 0; #1;
        chk("ready_after_rst", hs_ready_o, 1);
        // read len 3 @0x100, arready two cycles late
        hs_read_i = 1; hs_addr_i = 32'h100; hs_len_i = 4'd3;
        @(negedge clk_i); hs_read_i = 0; hs_addr_i = 32'hDEAD0; hs_len_i = 4'd9; #1;
        chk("ar_valid", arvalid_o, 1);
        chk("ar_addr", araddr_o, 'h100);
        chk("ar_len", arlen_o, 3);
        chk("ar_size", arsize_o, 2);
        chk("ar_burst", arburst_o, 1);
        chk("busy_ready", hs_ready_o, 0);
        chk("ar_no_aw", awvalid_o, 0);
        @(negedge clk_i); #1;
        chk("ar_hold_valid", arvalid_o, 1);
        chk("ar_hold_addr", araddr_o, 'h100);
        chk("ar_hold_len", arlen_o, 3);
        @(negedge clk_i); arready_i = 1; #1;
        chk("ar_valid_at_hs", arvalid_o, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); arready_i = 0; rvalid_i = 1; hs_rready_i = 1;
            rdata_i = 32'('hA0 + i); rlast_i = (i == 3); #1;
            chk("r1_data", hs_rdata_o, 64'('hA0 + i));
            chk("r1_valid", hs_rvalid_o, 1);
            chk("r1_ready", rready_o, 1);
            chk("r1_no_done", hs_done_o, 0);
            if (i == 0) chk("r1_ar_dropped", arvalid_o, 0);
        end
        @(negedge clk_i); rvalid_i = 0; rlast_i = 0; hs_rready_i = 0; #1;
        chk("r1_done", hs_done_o, 1);
        chk("r1_err", hs_err_o, 0);
        chk("r1_idle", hs_ready_o, 1);
        @(negedge clk_i); #1;
        chk("r1_done_pulse", hs_done_o, 0);
        // write len 0, awready three cycles after wready
        hs_write_i = 1; hs_addr_i = 32'h200; hs_len_i = 4'd0;
        @(negedge clk_i); hs_write_i = 0; hs_wvalid_i = 1; hs_wdata_i = 32'h55; wready_i = 1; #1;
        chk("w2_awvalid", awvalid_o, 1);
        chk("w2_awaddr", awaddr_o, 'h200);
        chk("w2_awlen", awlen_o, 0);
        chk("w2_awsize", awsize_o, 2);
        chk("w2_awburst", awburst_o, 1);
        chk("w2_wvalid", wvalid_o, 1);
        chk("w2_wlast", wlast_o, 1);
        chk("w2_wdata", wdata_o, 'h55);
        chk("w2_hs_wready", hs_wready_o, 1);
        @(negedge clk_i); hs_wvalid_i = 0; wready_i = 0; #1;
        chk("w2_w_closed", wvalid_o, 0);
        chk("w2_no_b_yet", bready_o, 0);
        chk("w2_aw_pending", awvalid_o, 1);
        @(negedge clk_i); #1;
        chk("w2_no_b_yet2", bready_o, 0);
        @(negedge clk_i); awready_i = 1; #1;
        chk("w2_no_b_yet3", bready_o, 0);
        @(negedge clk_i); awready_i = 0; bvalid_i = 1; bresp_i = 2'b00; #1;
        chk("w2_bready", bready_o, 1);
        chk("w2_aw_dropped", awvalid_o, 0);
        @(negedge clk_i); bvalid_i = 0; #1;
        chk("w2_done", hs_done_o, 1);
        chk("w2_err", hs_err_o, 0);
        chk("w2_bready_off", bready_o, 0);
        // write len 7, gapped wvalid, AW and last W together, SLVERR
        @(negedge clk_i); hs_write_i = 1; hs_addr_i = 32'h1000; hs_len_i = 4'd7;
        @(negedge clk_i); hs_write_i = 0; #1;
        chk("w3_awvalid", awvalid_o, 1);
        chk("w3_awlen", awlen_o, 7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i); hs_wvalid_i = 1; wready_i = 1; hs_wdata_i = 32'('h1000 + i);
            awready_i = (i == 7); #1;
            chk("w3_wvalid", wvalid_o, 1);
            chk("w3_wdata", wdata_o, 64'('h1000 + i));
            chk("w3_wlast", wlast_o, 64'(i == 7));
            chk("w3_aw_held", awvalid_o, 1);
            chk("w3_no_b", bready_o, 0);
            if (i < 7) begin
                @(negedge clk_i); hs_wvalid_i = 0; #1;
                chk("w3_gap", wvalid_o, 0);
            end
        end
        @(negedge clk_i); hs_wvalid_i = 0; wready_i = 0; awready_i = 0; #1;
        chk("w3_bready", bready_o, 1);
        chk("w3_aw_dropped", awvalid_o, 0);
        chk("w3_w_closed", wvalid_o, 0);
        bvalid_i = 1; bresp_i = 2'b10;
        @(negedge clk_i); bvalid_i = 0; bresp_i = 2'b00; #1;
        chk("w3_done", hs_done_o, 1);
        chk("w3_err", hs_err_o, 1);
        // read len 2, rlast early on beat 2, hs_rready stalls each beat
        @(negedge clk_i); hs_read_i = 1; hs_addr_i = 32'h2000; hs_len_i = 4'd2;
        @(negedge clk_i); hs_read_i = 0; arready_i = 1; #1;
        chk("r4_err_cleared", hs_err_o, 0);
        chk("r4_arlen", arlen_o, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); arready_i = 0; rvalid_i = 1; rdata_i = 32'('hB0 + i);
            rlast_i = (i == 1); hs_rready_i = 0; #1;
            chk("r4_stall", rready_o, 0);
            chk("r4_rvalid", hs_rvalid_o, 1);
            @(negedge clk_i); hs_rready_i = 1; #1;
            chk("r4_go", rready_o, 1);
            chk("r4_data", hs_rdata_o, 64'('hB0 + i));
            chk("r4_no_done", hs_done_o, 0);
        end
        @(negedge clk_i); rvalid_i = 0; rlast_i = 0; hs_rready_i = 0; #1;
        chk("r4_done", hs_done_o, 1);
        chk("r4_err", hs_err_o, 1);
        // read and write together: read first, write stays pending
        @(negedge clk_i); hs_read_i = 1; hs_write_i = 1; hs_addr_i = 32'h300; hs_len_i = 4'd0;
        @(negedge clk_i); hs_read_i = 0; arready_i = 1; #1;
        chk("rw_arvalid", arvalid_o, 1);
        chk("rw_no_aw", awvalid_o, 0);
        chk("rw_err_cleared", hs_err_o, 0);
        @(negedge clk_i); arready_i = 0; rvalid_i = 1; rlast_i = 1; hs_rready_i = 1; rdata_i = 32'hC0; #1;
        chk("rw_rvalid", hs_rvalid_o, 1);
        @(negedge clk_i); rvalid_i = 0; rlast_i = 0; hs_rready_i = 0; #1;
        chk("rw_read_done", hs_done_o, 1);
        chk("rw_idle", hs_ready_o, 1);
        chk("rw_aw_not_yet", awvalid_o, 0);
        @(negedge clk_i); hs_write_i = 0; hs_wvalid_i = 1; wready_i = 1; awready_i = 1; hs_wdata_i = 32'h77; #1;
        chk("rw_awvalid", awvalid_o, 1);
        chk("rw_awaddr", awaddr_o, 'h300);
        chk("rw_wlast", wlast_o, 1);
        chk("rw_no_done", hs_done_o, 0);
        @(negedge clk_i); hs_wvalid_i = 0; wready_i = 0; awready_i = 0; bvalid_i = 1; #1;
        chk("rw_bready", bready_o, 1);
        @(negedge clk_i); bvalid_i = 0; #1;
        chk("rw_write_done", hs_done_o, 1);
        chk("rw_write_err", hs_err_o, 0);
        // reset in the middle of a write, then a clean read
        @(negedge clk_i); hs_write_i = 1; hs_addr_i = 32'h500; hs_len_i = 4'd3;
        @(negedge clk_i); hs_write_i = 0; hs_wvalid_i = 1; wready_i = 1; hs_wdata_i = 32'h99; #1;
        chk("w6_wvalid", wvalid_o, 1);
        chk("w6_wlast", wlast_o, 0);
        @(negedge clk_i); #1;
        chk("w6_wvalid2", wvalid_o, 1);
        #2; rst_i = 1; #1;
        chk("mid_rst_awvalid", awvalid_o, 0);
        chk("mid_rst_wvalid", wvalid_o, 0);
        chk("mid_rst_hs_wready", hs_wready_o, 0);
        chk("mid_rst_ready", hs_ready_o, 0);
        chk("mid_rst_done", hs_done_o, 0);
        chk("mid_rst_err", hs_err_o, 0);
        chk("mid_rst_awaddr", awaddr_o, 0);
        @(posedge clk_i); #1;
        chk("mid_rst_no_done", hs_done_o, 0);
        @(negedge clk_i); rst_i = 0; hs_wvalid_i = 0; wready_i = 0; #1;
        chk("post_rst_ready", hs_ready_o, 1);
        chk("post_rst_no_done", hs_done_o, 0);
        hs_read_i = 1; hs_addr_i = 32'h400; hs_len_i = 4'd1;
        @(negedge clk_i); hs_read_i = 0; arready_i = 1; #1;
        chk("r7_araddr", araddr_o, 'h400);
        chk("r7_arlen", arlen_o, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); arready_i = 0; rvalid_i = 1; hs_rready_i = 1;
            rdata_i = 32'('hD0 + i); rlast_i = (i == 1); #1;
            chk("r7_data", hs_rdata_o, 64'('hD0 + i));
        end
        @(negedge clk_i); rvalid_i = 0; rlast_i = 0; hs_rready_i = 0; #1;
        chk("r7_done", hs_done_o, 1);
        chk("r7_err", hs_err_o, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
